// File: rtl/cond_unit.sv
// Execute-stage condition/flag unit: holds the NZCV register, evaluates the
// instruction condition field, and registers the condition-gated controls.
module cond_unit #(
  parameter int unsigned FLAG_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_i,
  input  logic [3:0]        cond,
  input  logic [FLAG_W-1:0] alu_flags,
  input  logic [1:0]        flag_w,
  input  logic              reg_w_i,
  input  logic              mem_w_i,
  input  logic              pc_s_i,
  input  logic              stall,
  input  logic              flush,
  output logic              cond_ex,
  output logic [FLAG_W-1:0] flags_q,
  output logic              valid_o,
  output logic              reg_w_o,
  output logic              mem_w_o,
  output logic              pc_s_o
);

  typedef enum logic [3:0] {
    CC_EQ = 4'h0, CC_NE = 4'h1, CC_CS = 4'h2, CC_CC = 4'h3,
    CC_MI = 4'h4, CC_PL = 4'h5, CC_VS = 4'h6, CC_VC = 4'h7,
    CC_HI = 4'h8, CC_LS = 4'h9, CC_GE = 4'hA, CC_LT = 4'hB,
    CC_GT = 4'hC, CC_LE = 4'hD, CC_AL = 4'hE, CC_NV = 4'hF
  } cond_e;

  logic [FLAG_W-1:0] r_flags;
  logic              r_valid;
  logic              r_reg_w;
  logic              r_mem_w;
  logic              r_pc_s;

  cond_e w_cond;
  logic  w_n;
  logic  w_z;
  logic  w_c;
  logic  w_v;
  logic  w_pass;
  logic  w_exec;

  assign w_cond = cond_e'(cond);
  assign w_n    = r_flags[3];
  assign w_z    = r_flags[2];
  assign w_c    = r_flags[1];
  assign w_v    = r_flags[0];

  always_comb begin
    w_pass = 1'b0;
    case (w_cond)
      CC_EQ:   w_pass = w_z;
      CC_NE:   w_pass = ~w_z;
      CC_CS:   w_pass = w_c;
      CC_CC:   w_pass = ~w_c;
      CC_MI:   w_pass = w_n;
      CC_PL:   w_pass = ~w_n;
      CC_VS:   w_pass = w_v;
      CC_VC:   w_pass = ~w_v;
      CC_HI:   w_pass = w_c & ~w_z;
      CC_LS:   w_pass = ~w_c | w_z;
      CC_GE:   w_pass = (w_n == w_v);
      CC_LT:   w_pass = (w_n != w_v);
      CC_GT:   w_pass = ~w_z & (w_n == w_v);
      CC_LE:   w_pass = w_z | (w_n != w_v);
      CC_AL:   w_pass = 1'b1;
      default: w_pass = 1'b0;
    endcase
  end

  assign cond_ex = w_pass;
  assign w_exec  = valid_i & w_pass & ~stall & ~flush;

  // Flags are checked against the pre-update value, so an instruction never
  // sees its own write; the next one sees it without any bypass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flags <= '0;
    end else if (w_exec) begin
      if (flag_w[1]) r_flags[3:2] <= alu_flags[3:2];
      if (flag_w[0]) r_flags[1:0] <= alu_flags[1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_reg_w <= 1'b0;
      r_mem_w <= 1'b0;
      r_pc_s  <= 1'b0;
    end else if (flush) begin
      r_valid <= 1'b0;
      r_reg_w <= 1'b0;
      r_mem_w <= 1'b0;
      r_pc_s  <= 1'b0;
    end else if (!stall) begin
      r_valid <= valid_i;
      r_reg_w <= reg_w_i & valid_i & w_pass;
      r_mem_w <= mem_w_i & valid_i & w_pass;
      r_pc_s  <= pc_s_i  & valid_i & w_pass;
    end
  end

  assign flags_q = r_flags;
  assign valid_o = r_valid;
  assign reg_w_o = r_reg_w;
  assign mem_w_o = r_mem_w;
  assign pc_s_o  = r_pc_s;

endmodule

// File: tb/tb_cond_unit.sv
// Bench for cond_unit: directed vector table, async-reset sequences, and
// randomized traffic checked against a behavioural model.
module tb_cond_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       valid_i;
  logic [3:0] cond;
  logic [3:0] alu_flags;
  logic [1:0] flag_w;
  logic       reg_w_i;
  logic       mem_w_i;
  logic       pc_s_i;
  logic       stall;
  logic       flush;
  logic       cond_ex;
  logic [3:0] flags_q;
  logic       valid_o;
  logic       reg_w_o;
  logic       mem_w_o;
  logic       pc_s_o;

  int unsigned n_pass = 0;
  int unsigned n_tot  = 0;

  cond_unit #(.FLAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .cond(cond),
    .alu_flags(alu_flags), .flag_w(flag_w), .reg_w_i(reg_w_i),
    .mem_w_i(mem_w_i), .pc_s_i(pc_s_i), .stall(stall), .flush(flush),
    .cond_ex(cond_ex), .flags_q(flags_q), .valid_o(valid_o),
    .reg_w_o(reg_w_o), .mem_w_o(mem_w_o), .pc_s_o(pc_s_o)
  );

  always #5 clk = ~clk;

  // ctl = {valid, reg_w, mem_w, pc_s, stall, flush}; e_out = {valid_o, reg_w_o, mem_w_o, pc_s_o}
  typedef struct packed {
    logic [3:0] cond;
    logic [3:0] alu;
    logic [1:0] fw;
    logic [5:0] ctl;
    logic       e_cx;
    logic [3:0] e_fl;
    logic [3:0] e_out;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  task automatic apply(input logic [3:0] c, input logic [3:0] a, input logic [1:0] fw,
                       input logic [5:0] ctl);
    cond = c; alu_flags = a; flag_w = fw;
    {valid_i, reg_w_i, mem_w_i, pc_s_i, stall, flush} = ctl;
  endtask

  function automatic logic [3:0] outs();
    return {valid_o, reg_w_o, mem_w_o, pc_s_o};
  endfunction

  // Condition codes pair up as (test, negated test); 1111 is never taken.
  function automatic logic m_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, base;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    if (c == 4'hF) return 1'b0;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return base ^ c[0];
  endfunction

  logic [3:0] m_flags;
  logic [3:0] m_out;

  initial begin
    rst_n = 1'b0;
    apply(4'hE, 4'h0, 2'b00, 6'b110000);

    // Reset held with a live AL instruction: nothing may move.
    @(posedge clk); @(posedge clk); #1;
    chk("rst_outs", outs(), 4'b0000);
    chk("rst_flags", flags_q, 4'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rel_outs", outs(), 4'b1100);
    chk("rel_flags", flags_q, 4'h0);

    tbl.push_back('{4'hE, 4'hA, 2'b11, 6'b110000, 1'b1, 4'hA, 4'b1100}); // AL write 1010
    tbl.push_back('{4'h2, 4'h0, 2'b00, 6'b110000, 1'b1, 4'hA, 4'b1100}); // CS passes
    tbl.push_back('{4'h0, 4'hF, 2'b11, 6'b110000, 1'b0, 4'hA, 4'b1000}); // EQ fails
    tbl.push_back('{4'hE, 4'h5, 2'b10, 6'b101000, 1'b1, 4'h6, 4'b1010}); // NZ only
    tbl.push_back('{4'hE, 4'h1, 2'b01, 6'b100100, 1'b1, 4'h5, 4'b1001}); // CV only
    tbl.push_back('{4'hE, 4'h9, 2'b11, 6'b100000, 1'b1, 4'h9, 4'b1000});
    tbl.push_back('{4'hA, 4'h0, 2'b00, 6'b000000, 1'b1, 4'h9, 4'b0000}); // GE
    tbl.push_back('{4'hB, 4'h0, 2'b00, 6'b000000, 1'b0, 4'h9, 4'b0000}); // LT
    tbl.push_back('{4'hC, 4'h0, 2'b00, 6'b000000, 1'b1, 4'h9, 4'b0000}); // GT
    tbl.push_back('{4'hD, 4'h0, 2'b00, 6'b000000, 1'b0, 4'h9, 4'b0000}); // LE
    tbl.push_back('{4'hE, 4'hC, 2'b11, 6'b100000, 1'b1, 4'hC, 4'b1000});
    tbl.push_back('{4'hC, 4'h0, 2'b00, 6'b000000, 1'b0, 4'hC, 4'b0000}); // GT with Z
    tbl.push_back('{4'hD, 4'h0, 2'b00, 6'b000000, 1'b1, 4'hC, 4'b0000}); // LE with Z
    tbl.push_back('{4'h1, 4'h3, 2'b11, 6'b111100, 1'b0, 4'hC, 4'b1000}); // NE suppressed
    tbl.push_back('{4'hE, 4'h3, 2'b11, 6'b110010, 1'b1, 4'hC, 4'b1000}); // stall x3
    tbl.push_back('{4'hE, 4'h3, 2'b11, 6'b110010, 1'b1, 4'hC, 4'b1000});
    tbl.push_back('{4'hE, 4'h3, 2'b11, 6'b110010, 1'b1, 4'hC, 4'b1000});
    tbl.push_back('{4'hE, 4'h3, 2'b11, 6'b110000, 1'b1, 4'h3, 4'b1100}); // consumed once
    tbl.push_back('{4'hE, 4'hF, 2'b11, 6'b110011, 1'b1, 4'h3, 4'b0000}); // stall+flush
    tbl.push_back('{4'h0, 4'hF, 2'b11, 6'b110001, 1'b0, 4'h3, 4'b0000}); // flush
    tbl.push_back('{4'hE, 4'hF, 2'b11, 6'b110010, 1'b1, 4'h3, 4'b0000}); // stall holds 0
    tbl.push_back('{4'h3, 4'hF, 2'b11, 6'b110000, 1'b0, 4'h3, 4'b1000}); // CC fails

    foreach (tbl[i]) begin
      apply(tbl[i].cond, tbl[i].alu, tbl[i].fw, tbl[i].ctl);
      #1;
      chk($sformatf("vec%0d_cond_ex", i), {3'b000, cond_ex}, {3'b000, tbl[i].e_cx});
      @(posedge clk); #1;
      chk($sformatf("vec%0d_flags", i), flags_q, tbl[i].e_fl);
      chk($sformatf("vec%0d_outs", i), outs(), tbl[i].e_out);
    end

    // Async reset arriving in the middle of a stalled cycle.
    apply(4'hE, 4'h7, 2'b11, 6'b110000);
    @(posedge clk); #1;
    chk("pre_rst_flags", flags_q, 4'h7);
    chk("pre_rst_outs", outs(), 4'b1100);
    apply(4'hE, 4'h8, 2'b11, 6'b110010);
    #2 rst_n = 1'b0;
    #1;
    chk("midstall_rst_flags", flags_q, 4'h0);
    chk("midstall_rst_outs", outs(), 4'b0000);
    @(posedge clk); #1;
    rst_n = 1'b1;
    apply(4'h0, 4'h0, 2'b00, 6'b000000);
    @(posedge clk); #1;
    chk("post_rst_flags", flags_q, 4'h0);
    chk("post_rst_outs", outs(), 4'b0000);

    // Reserved condition never passes, for every flag value.
    for (int f = 0; f < 16; f++) begin
      apply(4'hE, 4'(f), 2'b11, 6'b100000);
      @(posedge clk); #1;
      chk($sformatf("nv_load%0d", f), flags_q, 4'(f));
      apply(4'hF, 4'h0, 2'b00, 6'b000000);
      #1;
      chk($sformatf("nv_cond%0d", f), {3'b000, cond_ex}, 4'b0000);
      @(posedge clk); #1;
    end

    m_flags = 4'hF;
    m_out   = 4'b0000;
    for (int k = 0; k < 400; k++) begin
      logic [3:0] c, a;
      logic [1:0] fw;
      logic v, r, m, p, st, fl, cx;
      c  = 4'($urandom_range(0, 15));
      a  = 4'($urandom_range(0, 15));
      fw = 2'($urandom_range(0, 3));
      v  = ($urandom_range(0, 3) != 0);
      r  = 1'($urandom_range(0, 1));
      m  = 1'($urandom_range(0, 1));
      p  = 1'($urandom_range(0, 1));
      st = ($urandom_range(0, 3) == 0);
      fl = ($urandom_range(0, 7) == 0);
      apply(c, a, fw, {v, r, m, p, st, fl});
      cx = m_cond(c, m_flags);
      #1;
      chk($sformatf("rnd%0d_cond_ex", k), {3'b000, cond_ex}, {3'b000, cx});
      if (fl) begin
        m_out = 4'b0000;
      end else if (!st) begin
        m_out = {v, r & v & cx, m & v & cx, p & v & cx};
        if (v && cx) begin
          if (fw[1]) m_flags[3:2] = a[3:2];
          if (fw[0]) m_flags[1:0] = a[1:0];
        end
      end
      @(posedge clk); #1;
      chk($sformatf("rnd%0d_flags", k), flags_q, m_flags);
      chk($sformatf("rnd%0d_outs", k), outs(), m_out);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
